// File: rtl/window_pkg.sv
// Shared types and helpers for the sliding-window generator.
// The typedefs describe the default 8-bit, 3x3 configuration; the
// parameterised modules derive their own widths from the same helpers.
package window_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_IMAGE_WIDTH  = 640;
  localparam int DEF_IMAGE_HEIGHT = 480;
  localparam int DEF_WIN_SIZE     = 3;

  typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;
  typedef pixel_t [DEF_WIN_SIZE-1:0][DEF_WIN_SIZE-1:0] window_t;

  // Width of a position counter able to hold 0..n-1.
  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

  // LSB of window element (r,c) inside the flattened window vector.
  function automatic int win_elem_lsb(input int r, input int c,
                                      input int win_size, input int data_width);
    return (r * win_size + c) * data_width;
  endfunction

endpackage

// File: rtl/window_line_mem.sv
// One line buffer: synchronous write, asynchronous read of the old contents.
// Reading and writing the same address in one cycle returns the value from
// before the write, which is what lets the buffers be chained row to row.
module window_line_mem
  import window_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_IMAGE_WIDTH
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [cnt_w(DEPTH)-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH-1:0]     rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/window_gen.sv
// Streaming WIN_SIZE x WIN_SIZE window generator with built-in line buffers.
// Row 0 of the window is the current row, column WIN_SIZE-1 the newest pixel.
// Only windows lying fully inside one frame are emitted.
module window_gen
  import window_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int WIN_SIZE     = DEF_WIN_SIZE
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      s_valid,
  output logic                                      s_ready,
  input  logic [DATA_WIDTH-1:0]                     s_data,
  input  logic                                      s_sof,
  output logic                                      m_valid,
  input  logic                                      m_ready,
  output logic [WIN_SIZE*WIN_SIZE*DATA_WIDTH-1:0]   m_window,
  output logic [$clog2(IMAGE_WIDTH)-1:0]            m_x,
  output logic [$clog2(IMAGE_HEIGHT)-1:0]           m_y,
  output logic                                      m_eof,
  output logic                                      frame_err
);

  localparam int K  = WIN_SIZE;
  localparam int CW = cnt_w(IMAGE_WIDTH);
  localparam int RW = cnt_w(IMAGE_HEIGHT);
  localparam logic [CW-1:0] COL_MAX = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] COL_WIN = CW'(K - 1);
  localparam logic [RW-1:0] ROW_WIN = RW'(K - 1);

  typedef logic [DATA_WIDTH-1:0] pix_t;
  typedef pix_t [K-1:0][K-1:0] win_t;

  logic            accept;
  logic            qualify;
  logic [CW-1:0]   pix_col, col_q, col_d;
  logic [RW-1:0]   pix_row, row_q, row_d;
  pix_t [K-1:0]    new_col;
  pix_t [K-2:0]    mem_rdata;
  win_t            shift_q, shift_d;
  logic            frame_err_q, frame_err_d;
  logic            m_valid_q, m_valid_d;
  win_t            win_q, win_d;
  logic [CW-1:0]   x_q, x_d;
  logic [RW-1:0]   y_q, y_d;
  logic            eof_q, eof_d;

  assign s_ready = !m_valid_q || m_ready;
  assign accept  = s_valid && s_ready;

  // A start-of-frame pixel is always placed at (0,0), whatever the counters say.
  assign pix_col = s_sof ? '0 : col_q;
  assign pix_row = s_sof ? '0 : row_q;
  assign qualify = (pix_col >= COL_WIN) && (pix_row >= ROW_WIN);

  // Buffer k feeds window row k+1 and is refilled with what row k held.
  genvar gi;
  generate
    for (gi = 0; gi < K - 1; gi++) begin : g_line
      window_line_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMAGE_WIDTH)
      ) u_line (
        .clk   (clk),
        .we    (accept),
        .addr  (pix_col),
        .wdata (new_col[gi]),
        .rdata (mem_rdata[gi])
      );
    end
  endgenerate

  // Assemble the incoming window column: new pixel on top, older rows below.
  always_comb begin
    new_col    = '0;
    new_col[0] = s_data;
    for (int r = 1; r < K; r++) begin
      new_col[r] = mem_rdata[r-1];
    end
  end

  // Shift every window row left and insert the new column on the right.
  always_comb begin
    shift_d = shift_q;
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          shift_d[r][c] = shift_q[r][c+1];
        end
        shift_d[r][K-1] = new_col[r];
      end
    end
  end

  // Raster position tracking and mid-frame start-of-frame detection.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    frame_err_d = 1'b0;
    if (accept) begin
      frame_err_d = s_sof && ((col_q != '0) || (row_q != '0));
      if (pix_col == COL_MAX) begin
        col_d = '0;
        row_d = (pix_row == ROW_MAX) ? '0 : pix_row + RW'(1);
      end else begin
        col_d = pix_col + CW'(1);
        row_d = pix_row;
      end
    end
  end

  // Output register: load on a qualifying accept, drain on m_ready, else hold.
  always_comb begin
    m_valid_d = m_valid_q;
    win_d     = win_q;
    x_d       = x_q;
    y_d       = y_q;
    eof_d     = eof_q;
    if (accept && qualify) begin
      m_valid_d = 1'b1;
      win_d     = shift_d;
      x_d       = pix_col;
      y_d       = pix_row;
      eof_d     = (pix_col == COL_MAX) && (pix_row == ROW_MAX);
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      m_valid_q   <= 1'b0;
      win_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      eof_q       <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      m_valid_q   <= m_valid_d;
      win_q       <= win_d;
      x_q         <= x_d;
      y_q         <= y_d;
      eof_q       <= eof_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_window  = win_q;
  assign m_x       = x_q;
  assign m_y       = y_q;
  assign m_eof     = eof_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen: a 5x4 / 3x3 instance and an 8x6 / 5x5 instance.
module tb_window_gen;
  import window_pkg::*;

  localparam int DW   = 8;
  localparam int WA   = 5;
  localparam int HA   = 4;
  localparam int KA   = 3;
  localparam int WB   = 8;
  localparam int HB   = 6;
  localparam int KB   = 5;
  localparam int WINA = KA * KA * DW;
  localparam int WINB = KB * KB * DW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            s_valid_a = 1'b0, s_sof_a = 1'b0, m_ready_a = 1'b1;
  logic [DW-1:0]   s_data_a  = '0;
  logic            s_ready_a, m_valid_a, m_eof_a, frame_err_a;
  logic [WINA-1:0] m_window_a;
  logic [2:0]      m_x_a;
  logic [1:0]      m_y_a;

  logic            s_valid_b = 1'b0, s_sof_b = 1'b0, m_ready_b = 1'b1;
  logic [DW-1:0]   s_data_b  = '0;
  logic            s_ready_b, m_valid_b, m_eof_b, frame_err_b;
  logic [WINB-1:0] m_window_b;
  logic [2:0]      m_x_b;
  logic [2:0]      m_y_b;

  window_gen #(.DATA_WIDTH(DW), .IMAGE_WIDTH(WA), .IMAGE_HEIGHT(HA), .WIN_SIZE(KA)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data_a),
    .s_sof(s_sof_a), .m_valid(m_valid_a), .m_ready(m_ready_a), .m_window(m_window_a),
    .m_x(m_x_a), .m_y(m_y_a), .m_eof(m_eof_a), .frame_err(frame_err_a));

  window_gen #(.DATA_WIDTH(DW), .IMAGE_WIDTH(WB), .IMAGE_HEIGHT(HB), .WIN_SIZE(KB)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
    .s_sof(s_sof_b), .m_valid(m_valid_b), .m_ready(m_ready_b), .m_window(m_window_b),
    .m_x(m_x_b), .m_y(m_y_b), .m_eof(m_eof_b), .frame_err(frame_err_b));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { int x; int y; bit eof; int newest; } vec_t;
  vec_t tbl[6];

  typedef struct { int x; int y; bit eof; logic [WINB-1:0] win; } cap_t;
  cap_t q_a[$];
  cap_t q_b[$];
  cap_t tmp_a, tmp_b;
  int   ferr_cnt = 0;

  bit              stall_mode = 1'b0;
  bit              hold_low   = 1'b0;
  int              stall_cnt  = 0;
  logic [WINA-1:0] stall_win;

  task automatic check_int(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [WINB-1:0] act, input logic [WINB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Ramp-frame reference: element (r,c) of the window whose newest pixel is (x,y).
  function automatic logic [WINB-1:0] ramp_win(input int base, input int x, input int y,
                                               input int k, input int w);
    logic [WINB-1:0] v;
    v = '0;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < k; c++)
        v[win_elem_lsb(r, c, k, DW) +: DW] = DW'(base + (y - r) * w + (x - (k - 1) + c));
    return v;
  endfunction

  // Capture completed output handshakes and frame_err cycles between clock edges.
  always @(negedge clk) begin
    if (m_valid_a && m_ready_a) begin
      tmp_a.x = int'(m_x_a); tmp_a.y = int'(m_y_a); tmp_a.eof = m_eof_a; tmp_a.win = WINB'(m_window_a);
      q_a.push_back(tmp_a);
    end
    if (m_valid_b && m_ready_b) begin
      tmp_b.x = int'(m_x_b); tmp_b.y = int'(m_y_b); tmp_b.eof = m_eof_b; tmp_b.win = m_window_b;
      q_b.push_back(tmp_b);
    end
    if (frame_err_a) ferr_cnt++;
  end

  // Downstream ready for instance A: optional 3-cycle stall on window (3,2).
  always @(posedge clk) begin
    #1;
    if (hold_low) begin
      m_ready_a = 1'b0;
    end else if (stall_cnt == 0 && stall_mode && m_valid_a && m_x_a == 3'd3 && m_y_a == 2'd2) begin
      stall_win = m_window_a;
      stall_cnt = 1;
      m_ready_a = 1'b0;
    end else if (stall_cnt > 0 && stall_cnt < 3) begin
      check_vec($sformatf("stall_window_c%0d", stall_cnt), WINB'(m_window_a), WINB'(stall_win));
      check_int($sformatf("stall_x_c%0d", stall_cnt), longint'(m_x_a), 3);
      check_int($sformatf("stall_y_c%0d", stall_cnt), longint'(m_y_a), 2);
      check_int($sformatf("stall_valid_c%0d", stall_cnt), longint'(m_valid_a), 1);
      check_int($sformatf("stall_s_ready_c%0d", stall_cnt), longint'(s_ready_a), 0);
      stall_cnt++;
      m_ready_a = 1'b0;
    end else begin
      m_ready_a = 1'b1;
    end
  end

  task automatic send_a(input int d, input bit sof, input bit gaps);
    int  guard;
    bit  ok;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    s_valid_a = 1'b1;
    s_data_a  = DW'(d);
    s_sof_a   = sof;
    guard     = 0;
    forever begin
      @(negedge clk);
      ok = s_ready_a;
      @(posedge clk); #1;
      if (ok) break;
      guard++;
      if (guard > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: s_ready stuck at 0 for %0d cycles, expected accept", guard);
        break;
      end
    end
    s_valid_a = 1'b0;
    s_sof_a   = 1'b0;
  endtask

  task automatic send_frame_a(input int base, input bit gaps);
    for (int y = 0; y < HA; y++)
      for (int x = 0; x < WA; x++)
        send_a(base + y * WA + x, (x == 0 && y == 0), gaps);
  endtask

  task automatic drain();
    repeat (8) begin @(posedge clk); #1; end
  endtask

  task automatic check_frame_a(input string tag, input int base);
    check_int({tag, "_count"}, q_a.size(), 6);
    for (int i = 0; i < 6 && i < q_a.size(); i++) begin
      check_int($sformatf("%s_w%0d_x", tag, i), q_a[i].x, tbl[i].x);
      check_int($sformatf("%s_w%0d_y", tag, i), q_a[i].y, tbl[i].y);
      check_int($sformatf("%s_w%0d_eof", tag, i), q_a[i].eof, tbl[i].eof);
      check_int($sformatf("%s_w%0d_newest", tag, i),
                q_a[i].win[win_elem_lsb(0, KA - 1, KA, DW) +: DW], base + tbl[i].newest);
      check_vec($sformatf("%s_w%0d_window", tag, i), q_a[i].win,
                ramp_win(base, tbl[i].x, tbl[i].y, KA, WA));
    end
    q_a.delete();
  endtask

  initial begin
    tbl[0] = '{x: 2, y: 2, eof: 1'b0, newest: 12};
    tbl[1] = '{x: 3, y: 2, eof: 1'b0, newest: 13};
    tbl[2] = '{x: 4, y: 2, eof: 1'b0, newest: 14};
    tbl[3] = '{x: 2, y: 3, eof: 1'b0, newest: 17};
    tbl[4] = '{x: 3, y: 3, eof: 1'b0, newest: 18};
    tbl[5] = '{x: 4, y: 3, eof: 1'b1, newest: 19};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_int("rst_m_valid", m_valid_a, 0);
    check_vec("rst_m_window", WINB'(m_window_a), '0);
    check_int("rst_m_x", m_x_a, 0);
    check_int("rst_m_y", m_y_a, 0);
    check_int("rst_m_eof", m_eof_a, 0);
    check_int("rst_frame_err", frame_err_a, 0);
    check_int("rst_s_ready", s_ready_a, 1);
    check_int("rst_b_m_valid", m_valid_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain ramp frame
    ferr_cnt = 0;
    send_frame_a(0, 1'b0);
    drain();
    check_frame_a("ramp", 0);

    // Same frame with a downstream stall on the second window
    stall_cnt  = 0;
    stall_mode = 1'b1;
    send_frame_a(0, 1'b0);
    drain();
    stall_mode = 1'b0;
    check_int("stall_cycles", stall_cnt, 3);
    check_frame_a("stall", 0);

    // Two back-to-back frames with random input gaps
    send_frame_a(0, 1'b1);
    drain();
    check_frame_a("gap_f1", 0);
    send_frame_a(0, 1'b1);
    drain();
    check_frame_a("gap_f2", 0);
    check_int("no_frame_err", ferr_cnt, 0);

    // Aborted frame: new s_sof lands on position (3,1)
    ferr_cnt = 0;
    for (int i = 0; i < WA + 3; i++) send_a(50 + i, (i == 0), 1'b0);
    send_frame_a(100, 1'b0);
    drain();
    check_int("sof_err_pulses", ferr_cnt, 1);
    check_frame_a("resync", 100);

    // Asynchronous reset mid-frame while a window is held
    hold_low = 1'b1;
    for (int i = 0; i < 2 * WA + 3; i++) send_a(50 + i, (i == 0), 1'b0);
    @(posedge clk); #1;
    check_int("pre_rst_m_valid", m_valid_a, 1);
    check_int("pre_rst_m_x", m_x_a, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_int("arst_m_valid", m_valid_a, 0);
    check_vec("arst_m_window", WINB'(m_window_a), '0);
    check_int("arst_m_x", m_x_a, 0);
    check_int("arst_m_y", m_y_a, 0);
    check_int("arst_s_ready", s_ready_a, 1);
    @(negedge clk);
    rst_n    = 1'b1;
    hold_low = 1'b0;
    @(posedge clk); #1;
    q_a.delete();
    send_frame_a(200, 1'b0);
    drain();
    check_frame_a("post_reset", 200);

    // 5x5 window over an 8x6 ramp
    for (int y = 0; y < HB; y++) begin
      for (int x = 0; x < WB; x++) begin
        s_valid_b = 1'b1;
        s_data_b  = DW'(y * WB + x);
        s_sof_b   = (x == 0 && y == 0);
        @(posedge clk); #1;
      end
    end
    s_valid_b = 1'b0;
    s_sof_b   = 1'b0;
    drain();
    check_int("k5_count", q_b.size(), 8);
    if (q_b.size() > 0) begin
      check_int("k5_first_elem_4_0", q_b[0].win[win_elem_lsb(4, 0, KB, DW) +: DW], 0);
      check_int("k5_first_elem_0_4", q_b[0].win[win_elem_lsb(0, 4, KB, DW) +: DW], 36);
    end
    for (int i = 0; i < 8 && i < q_b.size(); i++) begin
      check_int($sformatf("k5_w%0d_x", i), q_b[i].x, 4 + i % 4);
      check_int($sformatf("k5_w%0d_y", i), q_b[i].y, 4 + i / 4);
      check_int($sformatf("k5_w%0d_eof", i), q_b[i].eof, (i == 7) ? 1 : 0);
      check_vec($sformatf("k5_w%0d_window", i), q_b[i].win,
                ramp_win(0, 4 + i % 4, 4 + i / 4, KB, WB));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
